// File: rtl/zmaps_wr_arb.sv
// zmaps_wr_arb: Z80 zmaps window / DMA arbiter for the shared CRAM/SFILE write port with a Z80 word FIFO.
// Optional macro ZMAPS_WR_ARB_COALESCE_EN merges an enqueue into a same-address FIFO tail entry.
module zmaps_wr_arb #(
  parameter int DEPTH = 4,
  parameter int STALL_MAX = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memwr_s,
  input  logic [15:0] a,
  input  logic [7:0]  d,
  input  logic [4:0]  fmaddr,
  input  logic        dma_req,
  input  logic        dma_sel,
  input  logic [7:0]  dma_wraddr,
  input  logic [15:0] dma_data,
  output logic        dma_ack,
  output logic [7:0]  ram_addr,
  output logic [15:0] ram_data,
  output logic        cram_we,
  output logic        sfile_we,
  output logic        z_full,
  output logic        z_ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  localparam logic [7:0] SMAX = 8'(STALL_MAX);
  typedef enum logic [1:0] {IDLE, DMA, FORCE, Z80} gnt_t;
  gnt_t gnt;
  logic hit, nonempty, push, pop, coal;
  logic enq_q, enq_d, ovf_q, ovf_d, cwe_q, cwe_d, swe_q, swe_d;
  logic [7:0] lo_q, lo_d, stall_q, stall_d, addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic [24:0] ew_q, ew_d, head;
  logic [24:0] mem_q [DEPTH];
  logic [24:0] mem_d [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d, tail;
  logic [AW:0] cnt_q, cnt_d;
  // Entries are {file, word addr[7:0], data[15:0]}; the odd byte is the high byte.
  always_comb begin
    hit = memwr_s & fmaddr[4] & (a[15:12] == fmaddr[3:0]) & (a[11:10] == 2'b00);
    lo_d = (hit & ~a[0]) ? d : lo_q;
    enq_d = hit & a[0];
    ew_d = enq_d ? {a[9], a[8:1], d, lo_q} : ew_q;
    nonempty = cnt_q != '0;
    head = mem_q[rp_q];
    tail = wp_q - AW'(1);
    gnt = (nonempty && stall_q == SMAX) ? FORCE : dma_req ? DMA : nonempty ? Z80 : IDLE;
    dma_ack = gnt == DMA;
    pop = (gnt == FORCE) || (gnt == Z80);
`ifdef ZMAPS_WR_ARB_COALESCE_EN
    coal = enq_q && nonempty && (mem_q[tail][24:16] == ew_q[24:16]) && !(pop && cnt_q == (AW+1)'(1));
`else
    coal = 1'b0;
`endif
    push = enq_q && !coal && (cnt_q != FULL || pop);
    ovf_d = ovf_q | (enq_q && !coal && cnt_q == FULL && !pop);
    mem_d = mem_q;
    if (coal) mem_d[tail][15:0] = ew_q[15:0];
    if (push) mem_d[wp_q] = ew_q;
    wp_d = wp_q + AW'(push);
    rp_d = rp_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    stall_d = (gnt == DMA && nonempty) ? stall_q + 8'd1 : 8'd0;
    addr_d = dma_ack ? dma_wraddr : pop ? head[23:16] : addr_q;
    data_d = dma_ack ? dma_data : pop ? head[15:0] : data_q;
    cwe_d = dma_ack ? ~dma_sel : pop & ~head[24];
    swe_d = dma_ack ? dma_sel : pop & head[24];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enq_q <= 1'b0;
      ew_q <= '0;
      lo_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      stall_q <= '0;
      ovf_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      cwe_q <= 1'b0;
      swe_q <= 1'b0;
    end else begin
      enq_q <= enq_d;
      ew_q <= ew_d;
      lo_q <= lo_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      stall_q <= stall_d;
      ovf_q <= ovf_d;
      addr_q <= addr_d;
      data_q <= data_d;
      cwe_q <= cwe_d;
      swe_q <= swe_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  assign ram_addr = addr_q;
  assign ram_data = data_q;
  assign cram_we = cwe_q;
  assign sfile_we = swe_q;
  assign z_ovf = ovf_q;
  assign z_full = cnt_q == FULL;
endmodule
